id_fetch_ctrl: RTL and testbench

- Consumer-side controller for the IF_ID pipeline register. It is the other end of the fetch-stage interface.
- Decodes the instruction and PC+4 held in IF_ID and detects load-use and jr hazards.
- Synchronises and latches external interrupts, and flags illegal instructions.
- Drives every fetch-stage control input: PC_IF_ID_Write, select_PC_next, status and the three redirect targets. Also records the EPC for the handler.

---
 rtl/id_fetch_ctrl.sv | 160 ++++++++++++++++
 tb/tb_id_fetch_ctrl.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_fetch_ctrl.sv
// id_fetch_ctrl: consumer side of IF_ID; decodes, detects hazards,
// latches interrupts and drives all fetch-stage redirect/status controls.
module id_fetch_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] IF_ID,
  input  logic [31:0] rs_data,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_branch_target,
  input  logic        id_ex_mem_read,
  input  logic [4:0]  id_ex_rt,
  input  logic        id_ex_reg_write,
  input  logic [4:0]  id_ex_dst,
  input  logic        irq,
  output logic        PC_IF_ID_Write,
  output logic [2:0]  select_PC_next,
  output logic [1:0]  status,
  output logic [31:0] branch_target,
  output logic [31:0] jump_target,
  output logic [31:0] jr_target,
  output logic        id_ex_bubble,
  output logic [31:0] epc,
  output logic        irq_pending
);

  localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [31:0] pc4;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;

  assign pc4   = IF_ID[63:32];
  assign instr = IF_ID[31:0];
  assign op    = instr[31:26];
  assign funct = instr[5:0];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];

  assign branch_target = ex_branch_target;
  assign jump_target   = {pc4[31:28], instr[25:0], 2'b00};
  assign jr_target     = rs_data;

  logic is_j;
  logic is_jr;
  logic op_ok;
  logic funct_ok;
  logic illegal;
  logic load_use;
  logic jr_haz;
  logic stall;

  always_comb begin
    op_ok = 1'b0;
    case (op)
      6'h00, 6'h02, 6'h03, 6'h04, 6'h05,
      6'h06, 6'h07, 6'h08, 6'h09, 6'h0A,
      6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
      6'h23, 6'h2B: op_ok = 1'b1;
      default:      op_ok = 1'b0;
    endcase
  end

  always_comb begin
    funct_ok = 1'b0;
    case (funct)
      6'h00, 6'h02, 6'h03, 6'h08, 6'h09,
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
      6'h25, 6'h26, 6'h27, 6'h2A,
      6'h2B:   funct_ok = 1'b1;
      default: funct_ok = 1'b0;
    endcase
  end

  assign is_j    = (op == 6'h02) || (op == 6'h03);
  assign is_jr   = (op == 6'h00) &&
                   ((funct == 6'h08) || (funct == 6'h09));
  assign illegal = !op_ok || ((op == 6'h00) && !funct_ok);

  assign load_use = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                    ((id_ex_rt == rs) || (id_ex_rt == rt));
  assign jr_haz   = is_jr && (rs != 5'd0) && id_ex_reg_write &&
                    (id_ex_dst == rs);
  assign stall    = load_use || jr_haz;

  logic [NS-1:0] sync_q;
  logic          irq_q;
  logic          irq_s;
  logic          irq_rise;
  logic          squash_q;
  logic          shadow_q;

  assign irq_s    = sync_q[NS-1];
  assign irq_rise = irq_s && !irq_q;

  logic take_exc;
  logic take_irq;
  logic take_jmp;

  always_comb begin
    PC_IF_ID_Write = 1'b1;
    select_PC_next = 3'b000;
    status         = 2'b00;
    id_ex_bubble   = 1'b0;
    take_exc       = 1'b0;
    take_irq       = 1'b0;
    take_jmp       = 1'b0;
    if (ex_branch_taken) begin
      select_PC_next = 3'b100;
      id_ex_bubble   = 1'b1;
    end else if (squash_q) begin
      id_ex_bubble   = 1'b1;
    end else if (stall) begin
      PC_IF_ID_Write = 1'b0;
      id_ex_bubble   = 1'b1;
    end else if (is_jr) begin
      select_PC_next = 3'b001;
      take_jmp       = 1'b1;
    end else if (is_j) begin
      select_PC_next = 3'b010;
      take_jmp       = 1'b1;
    end else if (illegal) begin
      status         = 2'b01;
      id_ex_bubble   = 1'b1;
      take_exc       = 1'b1;
    end else if (irq_pending && !pc4[31] && !shadow_q) begin
      // kernel-mode PCs and delay slots hold the interrupt off
      status         = 2'b10;
      id_ex_bubble   = 1'b1;
      take_irq       = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q      <= '0;
      irq_q       <= 1'b0;
      irq_pending <= 1'b0;
      epc         <= 32'd0;
      squash_q    <= 1'b0;
      shadow_q    <= 1'b0;
    end else begin
      sync_q   <= {sync_q[NS-2:0], irq};
      irq_q    <= irq_s;
      squash_q <= take_exc || take_irq;
      shadow_q <= take_jmp;
      if (irq_rise)
        irq_pending <= 1'b1;
      else if (take_irq)
        irq_pending <= 1'b0;
      if (take_exc || take_irq)
        epc <= pc4 - 32'd4;
    end
  end

endmodule

// File: tb/tb_id_fetch_ctrl.sv
// tb_id_fetch_ctrl: directed scenarios plus randomized run
// against a behavioural model of the ID fetch controller.
module tb_id_fetch_ctrl;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] IF_ID;
  logic [31:0] rs_data;
  logic        ex_branch_taken;
  logic [31:0] ex_branch_target;
  logic        id_ex_mem_read;
  logic [4:0]  id_ex_rt;
  logic        id_ex_reg_write;
  logic [4:0]  id_ex_dst;
  logic        irq;
  logic        PC_IF_ID_Write;
  logic [2:0]  select_PC_next;
  logic [1:0]  status;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] jr_target;
  logic        id_ex_bubble;
  logic [31:0] epc;
  logic        irq_pending;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] ADD = 32'h0044_1820;

  id_fetch_ctrl #(.SYNC_STAGES(S)) dut (
    .clk(clk),
    .reset(reset),
    .IF_ID(IF_ID),
    .rs_data(rs_data),
    .ex_branch_taken(ex_branch_taken),
    .ex_branch_target(ex_branch_target),
    .id_ex_mem_read(id_ex_mem_read),
    .id_ex_rt(id_ex_rt),
    .id_ex_reg_write(id_ex_reg_write),
    .id_ex_dst(id_ex_dst),
    .irq(irq),
    .PC_IF_ID_Write(PC_IF_ID_Write),
    .select_PC_next(select_PC_next),
    .status(status),
    .branch_target(branch_target),
    .jump_target(jump_target),
    .jr_target(jr_target),
    .id_ex_bubble(id_ex_bubble),
    .epc(epc),
    .irq_pending(irq_pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    IF_ID            = {32'h4, 32'h0};
    rs_data          = 32'h0;
    ex_branch_taken  = 1'b0;
    ex_branch_target = 32'h0;
    id_ex_mem_read   = 1'b0;
    id_ex_rt         = 5'd0;
    id_ex_reg_write  = 1'b0;
    id_ex_dst        = 5'd0;
    irq              = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    tick();
    n_checks++;
    if (epc !== 32'h0 || irq_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: epc=%h pend=%b want 0/0",
               epc, irq_pending);
    end
    @(negedge clk);
    n_checks++;
    if ({PC_IF_ID_Write, select_PC_next, status, id_ex_bubble}
        !== 7'b1_000_00_0) begin
      n_fail++;
      $display("FAIL reset_comb: wr=%b sel=%b st=%b bub=%b want 1/000/00/0",
               PC_IF_ID_Write, select_PC_next, status, id_ex_bubble);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_load_use();
    IF_ID          = {32'h104, ADD};
    id_ex_mem_read = 1'b1;
    id_ex_rt       = 5'd2;
    @(negedge clk);
    n_checks++;
    if (PC_IF_ID_Write !== 1'b0 || id_ex_bubble !== 1'b1) begin
      n_fail++;
      $display("FAIL load_use: wr=%b bub=%b want 0/1",
               PC_IF_ID_Write, id_ex_bubble);
    end
    tick();
    id_ex_mem_read = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({PC_IF_ID_Write, select_PC_next, id_ex_bubble} !== 5'b1_000_0) begin
      n_fail++;
      $display("FAIL load_use_release: wr=%b sel=%b bub=%b want 1/000/0",
               PC_IF_ID_Write, select_PC_next, id_ex_bubble);
    end
    tick();
    idle();
  endtask

  task automatic test_jump();
    IF_ID          = {32'h104, ADD};
    id_ex_mem_read = 1'b1;
    id_ex_rt       = 5'd2;
    irq            = 1'b1;
    tick();
    irq = 1'b0;
    tick();
    tick();
    n_checks++;
    if (irq_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL jump_pend: pend=%b want 1", irq_pending);
    end
    id_ex_mem_read = 1'b0;
    IF_ID          = {32'h104, 32'h0800_0040};
    @(negedge clk);
    n_checks++;
    if (select_PC_next !== 3'b010 || jump_target !== 32'h100 ||
        status !== 2'b00) begin
      n_fail++;
      $display("FAIL jump_sel: sel=%b jt=%h st=%b want 010/00000100/00",
               select_PC_next, jump_target, status);
    end
    tick();
    IF_ID = {32'h108, 32'h0};
    @(negedge clk);
    n_checks++;
    if (status !== 2'b00 || irq_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL jump_shadow: st=%b pend=%b want 00/1",
               status, irq_pending);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (status !== 2'b10 || id_ex_bubble !== 1'b1) begin
      n_fail++;
      $display("FAIL jump_irq_take: st=%b bub=%b want 10/1",
               status, id_ex_bubble);
    end
    tick();
    n_checks++;
    if (irq_pending !== 1'b0 || epc !== 32'h104) begin
      n_fail++;
      $display("FAIL jump_irq_epc: pend=%b epc=%h want 0/00000104",
               irq_pending, epc);
    end
    tick();
    idle();
  endtask

  task automatic test_branch_over_stall();
    IF_ID            = {32'h10, ADD};
    id_ex_mem_read   = 1'b1;
    id_ex_rt         = 5'd2;
    ex_branch_taken  = 1'b1;
    ex_branch_target = 32'h200;
    @(negedge clk);
    n_checks++;
    if ({PC_IF_ID_Write, select_PC_next, status, id_ex_bubble} !== 7'b1_100_00_1 ||
        branch_target !== 32'h200) begin
      n_fail++;
      $display("FAIL branch_over_stall: wr=%b sel=%b st=%b bub=%b bt=%h want 1/100/00/1/00000200",
               PC_IF_ID_Write, select_PC_next, status, id_ex_bubble, branch_target);
    end
    tick();
    idle();
  endtask

  task automatic test_illegal();
    IF_ID = {32'h10, 32'hFC00_0000};
    @(negedge clk);
    n_checks++;
    if (status !== 2'b01 || id_ex_bubble !== 1'b1 || select_PC_next !== 3'b000) begin
      n_fail++;
      $display("FAIL illegal_status: st=%b bub=%b sel=%b want 01/1/000",
               status, id_ex_bubble, select_PC_next);
    end
    tick();
    n_checks++;
    if (epc !== 32'hC) begin
      n_fail++;
      $display("FAIL illegal_epc: epc=%h want 0000000c", epc);
    end
    IF_ID = {32'h14, 32'h0};
    @(negedge clk);
    n_checks++;
    if (id_ex_bubble !== 1'b1 || select_PC_next !== 3'b000 || status !== 2'b00) begin
      n_fail++;
      $display("FAIL illegal_squash: bub=%b sel=%b st=%b want 1/000/00",
               id_ex_bubble, select_PC_next, status);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (id_ex_bubble !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_unsquash: bub=%b want 0", id_ex_bubble);
    end
    tick();
    idle();
  endtask

  task automatic test_irq();
    logic exp_p [3];
    exp_p[0] = 1'b0;
    exp_p[1] = 1'b0;
    exp_p[2] = 1'b1;
    IF_ID = {32'h20, 32'h0};
    irq   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      irq = 1'b0;
      n_checks++;
      if (irq_pending !== exp_p[k]) begin
        n_fail++;
        $display("FAIL irq_sync_edge%0d: pend=%b want %b",
                 k + 1, irq_pending, exp_p[k]);
      end
    end
    @(negedge clk);
    n_checks++;
    if (status !== 2'b10 || id_ex_bubble !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_take: st=%b bub=%b want 10/1", status, id_ex_bubble);
    end
    tick();
    n_checks++;
    if (irq_pending !== 1'b0 || epc !== 32'h1C) begin
      n_fail++;
      $display("FAIL irq_epc: pend=%b epc=%h want 0/0000001c",
               irq_pending, epc);
    end
    tick();
    idle();
  endtask

  task automatic test_mask_reset();
    IF_ID = {32'h8000_0020, 32'h0};
    irq   = 1'b1;
    tick();
    irq = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (status !== 2'b00 || irq_pending !== 1'b1) begin
        n_fail++;
        $display("FAIL mask_kernel%0d: st=%b pend=%b want 00/1",
                 k, status, irq_pending);
      end
      tick();
    end
    IF_ID = {32'h8000_0040, 32'hFC00_0000};
    tick();
    IF_ID = {32'h8000_0044, 32'h0};
    n_checks++;
    if (epc !== 32'h8000_003C) begin
      n_fail++;
      $display("FAIL mask_epc_bit31: epc=%h want 8000003c", epc);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (irq_pending !== 1'b0 || epc !== 32'h0 || id_ex_bubble !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: pend=%b epc=%h bub=%b want 0/0/0",
               irq_pending, epc, id_ex_bubble);
    end
    tick();
    reset = 1'b0;
    idle();
  endtask

  task automatic test_random(input int n);
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  irs;
    logic [4:0]  irt;
    logic        j, jr, legal, lu, jh;
    logic        acc_j, acc_x, acc_i, rise;
    logic [2:0]  e_sel;
    logic [1:0]  e_st;
    logic        e_wr, e_bub;
    logic [31:0] e_jt;
    logic        q[$];
    logic        m_pend, m_sq, m_sh, m_prev;
    logic [31:0] m_epc;
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
    q = {};
    for (int k = 0; k < S; k++) q.push_back(1'b0);
    m_pend = 1'b0;
    m_sq   = 1'b0;
    m_sh   = 1'b0;
    m_prev = 1'b0;
    m_epc  = 32'h0;
    for (int i = 0; i < n; i++) begin
      irs = 5'($urandom_range(0, 3));
      irt = 5'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0: instr = {($urandom_range(0, 1) == 1) ? 6'h02 : 6'h03, 26'($urandom)};
        1: instr = {6'h00, irs, 5'($urandom), 5'($urandom), 5'd0,
                    ($urandom_range(0, 1) == 1) ? 6'h08 : 6'h09};
        2: instr = 32'h0;
        3: instr = {6'h00, irs, irt, 5'($urandom), 5'd0, 6'($urandom)};
        4: instr = {6'($urandom), irs, irt, 16'($urandom)};
        5: instr = {6'h23, irs, irt, 16'($urandom)};
        default: instr = {6'h00, irs, irt, 5'd3, 5'd0, 6'h20};
      endcase
      pc4 = {($urandom_range(0, 7) == 0), 31'($urandom)};
      IF_ID            = {pc4, instr};
      rs_data          = $urandom;
      ex_branch_taken  = ($urandom_range(0, 7) == 0);
      ex_branch_target = $urandom;
      id_ex_mem_read   = ($urandom_range(0, 3) == 0);
      id_ex_rt         = 5'($urandom_range(0, 3));
      id_ex_reg_write  = ($urandom_range(0, 1) == 1);
      id_ex_dst        = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) irq = ~irq;
      reset = ($urandom_range(0, 99) == 0);
      if (reset) begin
        for (int k = 0; k < S; k++) q[k] = 1'b0;
        m_pend = 1'b0;
        m_sq   = 1'b0;
        m_sh   = 1'b0;
        m_prev = 1'b0;
        m_epc  = 32'h0;
      end
      op  = instr[31:26];
      fn  = instr[5:0];
      irs = instr[25:21];
      irt = instr[20:16];
      j  = op inside {6'h02, 6'h03};
      jr = (op == 6'h00) && (fn inside {6'h08, 6'h09});
      if (op == 6'h00)
        legal = fn inside {6'h00, 6'h02, 6'h03, 6'h08, 6'h09,
                           [6'h20:6'h27], 6'h2A, 6'h2B};
      else
        legal = op inside {[6'h02:6'h0F], 6'h23, 6'h2B};
      lu = id_ex_mem_read && id_ex_rt != 0 && (id_ex_rt == irs || id_ex_rt == irt);
      jh = jr && irs != 0 && id_ex_reg_write && id_ex_dst == irs;
      e_wr  = 1'b1;
      e_sel = 3'b000;
      e_st  = 2'b00;
      e_bub = 1'b0;
      acc_j = 1'b0;
      acc_x = 1'b0;
      acc_i = 1'b0;
      if (ex_branch_taken) begin
        e_sel = 3'b100; e_bub = 1'b1;
      end else if (m_sq) begin
        e_bub = 1'b1;
      end else if (lu || jh) begin
        e_wr = 1'b0; e_bub = 1'b1;
      end else if (jr) begin
        e_sel = 3'b001; acc_j = 1'b1;
      end else if (j) begin
        e_sel = 3'b010; acc_j = 1'b1;
      end else if (!legal) begin
        e_st = 2'b01; e_bub = 1'b1; acc_x = 1'b1;
      end else if (m_pend && !pc4[31] && !m_sh) begin
        e_st = 2'b10; e_bub = 1'b1; acc_i = 1'b1;
      end
      e_jt = {pc4[31:28], instr[25:0], 2'b00};
      @(negedge clk);
      n_checks++;
      if ({PC_IF_ID_Write, select_PC_next, status, id_ex_bubble,
           branch_target, jump_target, jr_target} !==
          {e_wr, e_sel, e_st, e_bub, ex_branch_target, e_jt, rs_data}) begin
        n_fail++;
        $display("FAIL rand_comb[%0d]: wr/sel/st/bub=%b/%b/%b/%b bt=%h jt=%h jrt=%h want %b/%b/%b/%b %h %h %h",
                 i, PC_IF_ID_Write, select_PC_next, status, id_ex_bubble,
                 branch_target, jump_target, jr_target,
                 e_wr, e_sel, e_st, e_bub, ex_branch_target, e_jt, rs_data);
      end
      n_checks++;
      if ((select_PC_next != 3'b000 && status != 2'b00) ||
          select_PC_next == 3'b011 || status == 2'b11) begin
        n_fail++;
        $display("FAIL rand_invariant[%0d]: sel=%b st=%b want exclusive one-hot",
                 i, select_PC_next, status);
      end
      if (!reset) begin
        rise = q[0] && !m_prev;
        if (rise)       m_pend = 1'b1;
        else if (acc_i) m_pend = 1'b0;
        if (acc_x || acc_i) m_epc = pc4 - 32'd4;
        m_sq   = acc_x || acc_i;
        m_sh   = acc_j;
        m_prev = q[0];
        q.push_back(irq);
        void'(q.pop_front());
      end
      tick();
      n_checks++;
      if (epc !== m_epc || irq_pending !== m_pend) begin
        n_fail++;
        $display("FAIL rand_state[%0d]: epc=%h pend=%b want %h/%b",
                 i, epc, irq_pending, m_epc, m_pend);
      end
    end
    reset = 1'b0;
    idle();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_load_use();
    test_jump();
    test_branch_over_stall();
    test_illegal();
    test_irq();
    test_mask_reset();
    test_random(1500);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
